// File: rtl/subleq_pkg.sv
// rtl/subleq_pkg.sv - shared types and constants for the SUBLEQ core
// Contents: state_e (controller states), INSTR_LEN, operand word offsets.
package subleq_pkg;

    typedef enum logic [3:0] {
        S_IDLE,
        S_F_A,
        S_F_B,
        S_F_C,
        S_R_A,
        S_R_B,
        S_WAIT,
        S_EXEC,
        S_HALT
    } state_e;

    localparam int INSTR_LEN = 3;
    localparam int OFF_A     = 0;
    localparam int OFF_B     = 1;
    localparam int OFF_C     = 2;

endpackage

// File: rtl/subleq_if.sv
// rtl/subleq_if.sv - word-memory bus between the SUBLEQ core and its memory
// Signals: mem_addr, mem_wdata, mem_we, mem_re (core -> memory), mem_rdata (memory -> core,
// valid the cycle after mem_re). Modports: master (core), slave (memory).
interface subleq_if #(
    parameter int DATA_W = 64
);
    logic [DATA_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_we;
    logic              mem_re;
    logic [DATA_W-1:0] mem_rdata;

    modport master (
        output mem_addr,
        output mem_wdata,
        output mem_we,
        output mem_re,
        input  mem_rdata
    );

    modport slave (
        input  mem_addr,
        input  mem_wdata,
        input  mem_we,
        input  mem_re,
        output mem_rdata
    );
endinterface

// File: rtl/subleq_alu.sv
// rtl/subleq_alu.sv - SUBLEQ datapath: diff = op_b - op_a (wrapping), leq = diff <= 0 signed
// Ports: op_a, op_b (in, DATA_W); diff (out, DATA_W); leq (out, 1).
module subleq_alu
    import subleq_pkg::*;
#(
    parameter int DATA_W = 64
) (
    input  logic [DATA_W-1:0] op_a,
    input  logic [DATA_W-1:0] op_b,
    output logic [DATA_W-1:0] diff,
    output logic              leq
);
    assign diff = op_b - op_a;
    // Judged on the wrapped result, so an overflowing subtraction can read as positive.
    assign leq  = (diff == '0) | diff[DATA_W-1];
endmodule

// File: rtl/subleq_core.sv
// rtl/subleq_core.sv - SUBLEQ execution controller, 7 cycles per instruction, one memory access per cycle
// Ports: clk, rst_n (async active-low), start (pulse, honoured in IDLE/HALT), busy, halted, pc,
// bus (subleq_if.master to the word memory), instr_count (retired instructions).
// Build option: SUBLEQ_ICOUNT_EN builds the retired-instruction counter; otherwise instr_count is 0.
module subleq_core
    import subleq_pkg::*;
#(
    parameter int                DATA_W   = 64,
    parameter logic [DATA_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    output logic              busy,
    output logic              halted,
    output logic [DATA_W-1:0] pc,
    subleq_if.master          bus,
    output logic [31:0]       instr_count
);
    state_e            state_q, state_d;
    logic [DATA_W-1:0] pc_q, pc_d;
    logic [DATA_W-1:0] a_q, a_d, b_q, b_d, c_q, c_d;
    logic [DATA_W-1:0] opa_q, opa_d, opb_q, opb_d;
    logic [DATA_W-1:0] diff;
    logic              leq;
    logic              idle_like;

    subleq_alu #(.DATA_W(DATA_W)) u_alu (
        .op_a (opa_q),
        .op_b (opb_q),
        .diff (diff),
        .leq  (leq)
    );

    assign idle_like = (state_q == S_IDLE) || (state_q == S_HALT);
    assign busy      = !idle_like;
    assign halted    = (state_q == S_HALT);
    assign pc        = pc_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            pc_q    <= RESET_PC;
            a_q     <= '0;
            b_q     <= '0;
            c_q     <= '0;
            opa_q   <= '0;
            opb_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            a_q     <= a_d;
            b_q     <= b_d;
            c_q     <= c_d;
            opa_q   <= opa_d;
            opb_q   <= opb_d;
        end
    end

    // Each state issues one access and captures the data requested by the previous state.
    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        a_d           = a_q;
        b_d           = b_q;
        c_d           = c_q;
        opa_d         = opa_q;
        opb_d         = opb_q;
        bus.mem_addr  = '0;
        bus.mem_wdata = '0;
        bus.mem_we    = 1'b0;
        bus.mem_re    = 1'b0;
        case (state_q)
            S_IDLE, S_HALT: begin
                if (start) begin
                    state_d = S_F_A;
                    pc_d    = RESET_PC;
                end
            end
            S_F_A: begin
                bus.mem_re   = 1'b1;
                bus.mem_addr = pc_q + DATA_W'(OFF_A);
                state_d      = S_F_B;
            end
            S_F_B: begin
                bus.mem_re   = 1'b1;
                bus.mem_addr = pc_q + DATA_W'(OFF_B);
                a_d          = bus.mem_rdata;
                state_d      = S_F_C;
            end
            S_F_C: begin
                bus.mem_re   = 1'b1;
                bus.mem_addr = pc_q + DATA_W'(OFF_C);
                b_d          = bus.mem_rdata;
                state_d      = S_R_A;
            end
            S_R_A: begin
                bus.mem_re   = 1'b1;
                bus.mem_addr = a_q;
                c_d          = bus.mem_rdata;
                state_d      = S_R_B;
            end
            S_R_B: begin
                bus.mem_re   = 1'b1;
                bus.mem_addr = b_q;
                opa_d        = bus.mem_rdata;
                state_d      = S_WAIT;
            end
            S_WAIT: begin
                opb_d   = bus.mem_rdata;
                state_d = S_EXEC;
            end
            S_EXEC: begin
                bus.mem_we    = 1'b1;
                bus.mem_addr  = b_q;
                bus.mem_wdata = diff;
                if (leq) begin
                    pc_d    = c_q;
                    // A negative target only halts when the branch is actually taken.
                    state_d = c_q[DATA_W-1] ? S_HALT : S_F_A;
                end else begin
                    pc_d    = pc_q + DATA_W'(INSTR_LEN);
                    state_d = S_F_A;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

`ifdef SUBLEQ_ICOUNT_EN
    logic [31:0] icount_q, icount_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            icount_q <= '0;
        end else begin
            icount_q <= icount_d;
        end
    end

    always_comb begin
        icount_d = icount_q;
        if (idle_like && start) begin
            icount_d = '0;
        end else if (state_q == S_EXEC) begin
            icount_d = icount_q + 32'd1;
        end
    end

    assign instr_count = icount_q;
`else
    assign instr_count = '0;
`endif

endmodule
